// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA timing generator: FSM states,
// default 800x480 timing and fixed colours.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_FILL = 2'd1,
        ST_RUN       = 2'd2
    } vga_state_e;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;

    localparam logic [23:0] RGB_BLACK     = 24'h000000;
    localparam logic [23:0] RGB_UNDERFLOW = 24'hFF00FF;

    // True when v lies in the half-open window [lo, hi).
    function automatic logic in_window(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_counter.sv
// Free-running modulo-MOD counter with enable; wrap is high in the cycle
// the counter steps from MOD-1 back to 0, so a cascaded counter steps with it.
module vga_counter #(
    parameter int MOD = 2,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    // Next count and wrap strobe.
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = {W{1'b0}};
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
                wrap  = 1'b0;
            end
        end else begin
            cnt_d = cnt_q;
            wrap  = 1'b0;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator fed by a show-ahead RGB FIFO; starts streaming at the
// first frame start after the FIFO fills. Define VGA_TEST_PATTERN_EN to replace
// the FIFO path with 8 vertical colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int VDISP  = DEF_VDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst_n,
    input  logic [23:0] fifo_rdata,
    input  logic        fifo_rempty,
    input  logic        fifo_wfull,
    output logic        fifo_read,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank,
    output logic [23:0] vga_rgb,
    output logic        underflow
);

    localparam int HTOT = HFP + HPULSE + HBP + HDISP;
    localparam int VTOT = VFP + VPULSE + VBP + VDISP;
    localparam int HW   = $clog2(HTOT);
    localparam int VW   = $clog2(VTOT);

    logic [HW-1:0] h_cnt_s;
    logic [VW-1:0] v_cnt_s;
    logic          h_wrap_s;
    logic          v_wrap_unused_s;

    vga_counter #(.MOD(HTOT), .W(HW)) u_h_counter (
        .clk   (pixel_clk),
        .rst_n (pixel_rst_n),
        .en    (1'b1),
        .cnt   (h_cnt_s),
        .wrap  (h_wrap_s)
    );

    vga_counter #(.MOD(VTOT), .W(VW)) u_v_counter (
        .clk   (pixel_clk),
        .rst_n (pixel_rst_n),
        .en    (h_wrap_s),
        .cnt   (v_cnt_s),
        .wrap  (v_wrap_unused_s)
    );

    vga_state_e  state_d, state_q;
    logic        hs_d, hs_q;
    logic        vs_d, vs_q;
    logic        blank_d, blank_q;
    logic [23:0] rgb_d, rgb_q;
    logic        underflow_d, underflow_q;

    logic        h_act_s, v_act_s, active_s;
    logic        frame_start_s, start_ok_s;
    logic        need_read_s;
    logic [23:0] pixel_s;

    // Layout decode: front porch, sync, back porch, then the visible area last.
    always_comb begin
        h_act_s       = in_window(32'(h_cnt_s), HTOT - HDISP, HTOT);
        v_act_s       = in_window(32'(v_cnt_s), VTOT - VDISP, VTOT);
        active_s      = h_act_s && v_act_s;
        hs_d          = !in_window(32'(h_cnt_s), HFP, HFP + HPULSE);
        vs_d          = !in_window(32'(v_cnt_s), VFP, VFP + VPULSE);
        blank_d       = active_s;
        frame_start_s = (h_cnt_s == {HW{1'b0}}) && (v_cnt_s == {VW{1'b0}});
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [HW-1:0] x_s;
    logic [2:0]    bar_s;
    logic          fifo_unused_s;

    // Bar index of the current visible column.
    always_comb begin
        x_s           = h_cnt_s - HW'(HTOT - HDISP);
        bar_s         = 3'((32'(x_s) * 32'd8) / 32'(HDISP));
        fifo_unused_s = ^{fifo_rdata, fifo_rempty, fifo_wfull};
        start_ok_s    = 1'b1;
        need_read_s   = (state_q == ST_RUN) && active_s;
        fifo_read     = 1'b0;
        underflow_d   = 1'b0;
        pixel_s       = {{8{bar_s[2]}}, {8{bar_s[1]}}, {8{bar_s[0]}}};
    end
`else
    // FIFO pixel path; an empty FIFO when a pixel is due shows magenta.
    always_comb begin
        start_ok_s  = fifo_wfull;
        need_read_s = (state_q == ST_RUN) && active_s;
        fifo_read   = need_read_s && !fifo_rempty;
        underflow_d = underflow_q || (need_read_s && fifo_rempty);
        if (fifo_rempty) begin
            pixel_s = RGB_UNDERFLOW;
        end else begin
            pixel_s = fifo_rdata;
        end
    end
`endif

    // Next state: streaming only begins on a frame boundary.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT_FILL;
            end
            ST_WAIT_FILL: begin
                if (start_ok_s && frame_start_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WAIT_FILL;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pixel colour: black outside the visible area and before streaming starts.
    always_comb begin
        if (need_read_s) begin
            rgb_d = pixel_s;
        end else begin
            rgb_d = RGB_BLACK;
        end
    end

    // State and output registers.
    always_ff @(posedge pixel_clk or negedge pixel_rst_n) begin
        if (!pixel_rst_n) begin
            state_q     <= ST_IDLE;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            blank_q     <= 1'b0;
            rgb_q       <= RGB_BLACK;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            blank_q     <= blank_d;
            rgb_q       <= rgb_d;
            underflow_q <= underflow_d;
        end
    end

    assign vga_hs    = hs_q;
    assign vga_vs    = vs_q;
    assign vga_blank = blank_q;
    assign vga_rgb   = rgb_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen at 160x90 (HTOT=288, VTOT=135,
// 38880 cycles per frame). cyc = pixel clocks since reset release.
module tb_vga_timing_gen;

    localparam logic [23:0] BASE = 24'h000100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [23:0] rdata;
    logic        rempty = 1'b0;
    logic        wfull = 1'b0;
    logic        fifo_read;
    logic        hs, vs, blank, underflow;
    logic [23:0] rgb;

    int cyc = 0;
    int rd_total = 0;
    int rd_mark = 0;
    int n_vec = 0;
    int n_miss = 0;
    int blank_cnt = 0, hs_low_cnt = 0, vs_low_cnt = 0;
    int magenta_cnt = 0, bad_blank_cnt = 0, early_color_cnt = 0;
    logic mon_en = 1'b0;

    vga_timing_gen #(.HDISP(160), .VDISP(90)) dut (
        .pixel_clk   (clk),
        .pixel_rst_n (rst_n),
        .fifo_rdata  (rdata),
        .fifo_rempty (rempty),
        .fifo_wfull  (wfull),
        .fifo_read   (fifo_read),
        .vga_hs      (hs),
        .vga_vs      (vs),
        .vga_blank   (blank),
        .vga_rgb     (rgb),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Show-ahead FIFO model: incrementing words, one pop per fifo_read cycle.
    always @(posedge clk) begin
        if (fifo_read) rd_total <= rd_total + 1;
    end
    assign rdata = BASE + rd_total[23:0];

    always @(negedge clk) begin
        if (mon_en) begin
            if (cyc >= 1 && cyc <= 38880) begin
                if (blank) blank_cnt <= blank_cnt + 1;
                if (!hs)   hs_low_cnt <= hs_low_cnt + 1;
                if (!vs)   vs_low_cnt <= vs_low_cnt + 1;
            end
            if (cyc < 51969 && rgb != 24'h0) early_color_cnt <= early_color_cnt + 1;
            if (rgb == 24'hFF00FF)           magenta_cnt <= magenta_cnt + 1;
            if (!blank && rgb != 24'h0)      bad_blank_cnt <= bad_blank_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick_to(input int target);
        int guard = 0;
        while (cyc < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) check_val("tick_to", cyc, target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_hs"}, hs, 1'b1);
        check_val({tag, "_vs"}, vs, 1'b1);
        check_val({tag, "_blank"}, blank, 1'b0);
        check_val({tag, "_rgb"}, rgb, 24'h0);
        check_val({tag, "_underflow"}, underflow, 1'b0);
        check_val({tag, "_fifo_read"}, fifo_read, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

`ifdef VGA_TEST_PATTERN_EN
        rempty = 1'b1;
        tick_to(38881);
        for (int i = 0; i < 160; i++) begin
            logic [2:0] bar;
            bar = 3'(i / 20);
            tick_to(51969 + i);
            check_val("bar_pixel", rgb, {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}});
        end
        check_val("pattern_no_reads", rd_total, 0);
        check_val("pattern_no_underflow", underflow, 1'b0);
`else
        mon_en = 1'b1;
        // hs: low for counter values 40..87, registered one cycle later
        tick_to(40);   check_val("hs_before", hs, 1'b1);
        tick_to(41);   check_val("hs_fall", hs, 1'b0);
        tick_to(88);   check_val("hs_last_low", hs, 1'b0);
        tick_to(89);   check_val("hs_rise", hs, 1'b1);
        tick_to(3744); check_val("vs_before", vs, 1'b1);
        tick_to(3745); check_val("vs_fall", vs, 1'b0);
        tick_to(4608); check_val("vs_last_low", vs, 1'b0);
        tick_to(4609); check_val("vs_rise", vs, 1'b1);
        tick_to(13088);
        check_val("wait_no_read", fifo_read, 1'b0);
        check_val("blank_pre_active", blank, 1'b0);
        tick_to(13089);
        check_val("blank_first_active", blank, 1'b1);
        check_val("black_before_run", rgb, 24'h0);
        tick_to(20000);
        wfull = 1'b1;
        tick_to(38881);
        check_val("frame_blank_cycles", blank_cnt, 14400);
        check_val("frame_hs_low_cycles", hs_low_cnt, 6480);
        check_val("frame_vs_low_cycles", vs_low_cnt, 864);
        tick_to(42624); check_val("vs_f1_before", vs, 1'b1);
        tick_to(42625); check_val("vs_f1_fall", vs, 1'b0);
        tick_to(51967);
        check_val("no_read_before_active", rd_total, 0);
        check_val("read_low_h127", fifo_read, 1'b0);
        tick_to(51968);
        check_val("first_read", fifo_read, 1'b1);
        check_val("blank_lags_read", blank, 1'b0);
        tick_to(51969);
        check_val("first_pixel_blank", blank, 1'b1);
        check_val("first_pixel_rgb", rgb, BASE);
        tick_to(52128);
        check_val("last_pixel_rgb", rgb, BASE + 24'd159);
        check_val("reads_per_line", rd_total, 160);
        tick_to(52129);
        check_val("line_end_blank", blank, 1'b0);
        check_val("line_end_rgb", rgb, 24'h0);
        tick_to(52255);
        rempty = 1'b1;
        tick_to(52256);
        check_val("empty_no_read", fifo_read, 1'b0);
        check_val("underflow_before", underflow, 1'b0);
        tick_to(52257);
        check_val("underflow_pixel_first", rgb, 24'hFF00FF);
        check_val("underflow_set", underflow, 1'b1);
        tick_to(52261);
        check_val("underflow_pixel_last", rgb, 24'hFF00FF);
        check_val("empty_reads_held", rd_total, 160);
        rempty = 1'b0;
        tick_to(52262);
        check_val("resume_pixel", rgb, BASE + 24'd160);
        check_val("resume_read", rd_total, 161);
        tick_to(56360);
        check_val("magenta_pixels", magenta_cnt, 5);
        check_val("rgb_black_when_blanked", bad_blank_cnt, 0);
        check_val("black_first_frame", early_color_cnt, 0);
        check_val("underflow_sticky", underflow, 1'b1);
        check_val("mid_frame_blank", blank, 1'b1);
        check_val("mid_frame_read", fifo_read, 1'b1);
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        rd_mark = rd_total;
        tick_to(41);
        check_val("restart_hs_fall", hs, 1'b0);
        tick_to(13088);
        check_val("restart_wait_no_read", fifo_read, 1'b0);
        tick_to(13089);
        check_val("restart_blank", blank, 1'b1);
        check_val("restart_black", rgb, 24'h0);
        check_val("restart_reads", rd_total, rd_mark);
        check_val("restart_underflow_clear", underflow, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter HDISP, default 800, visible pixels per line.
REQ-002 SHALL have parameter VDISP, default 480, visible lines per frame.
REQ-003 SHALL have parameters HFP=40, HPULSE=48, HBP=40, VFP=13, VPULSE=3, VBP=29: porch and sync widths in pixels and lines.
REQ-004 SHALL have port pixel_clk, input, 1, pixel clock; the only clock.
REQ-005 SHALL have port pixel_rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port fifo_rdata, input, 24, show-ahead RGB word from the upstream FIFO.
REQ-007 SHALL have port fifo_rempty, input, 1, upstream FIFO empty.
REQ-008 SHALL have port fifo_wfull, input, 1, upstream FIFO full; used as the start threshold.
REQ-009 SHALL have port fifo_read, output, 1, pops one word in the cycle it is high.
REQ-010 SHALL have port vga_hs, output, 1, horizontal sync, active-low.
REQ-011 SHALL have port vga_vs, output, 1, vertical sync, active-low.
REQ-012 SHALL have port vga_blank, output, 1, high in the visible area (DE).
REQ-013 SHALL have port vga_rgb, output, 24, pixel colour.
REQ-014 SHALL have port underflow, output, 1, sticky flag: a read was needed while the FIFO was empty.

Function
REQ-015 h_cnt SHALL count 0..HTOT-1 with HTOT=HFP+HPULSE+HBP+HDISP, then wrap to 0.
REQ-016 v_cnt SHALL increment when h_cnt wraps and SHALL count 0..VTOT-1 with VTOT=VFP+VPULSE+VBP+VDISP, then wrap to 0.
REQ-017 Horizontal line layout SHALL be, in order: front porch [0,HFP), sync [HFP,HFP+HPULSE), back porch, then active area [HTOT-HDISP,HTOT).
REQ-018 Vertical frame layout SHALL be the same ordering using VFP, VPULSE, VBP and VDISP.
REQ-019 Counter widths SHALL be $clog2(HTOT) and $clog2(VTOT).
REQ-020 The FSM SHALL have states IDLE, WAIT_FILL and RUN.
REQ-021 FSM transitions SHALL be: IDLE->WAIT_FILL on the first cycle after reset.
REQ-022 WAIT_FILL->RUN SHALL occur when fifo_wfull=1 while h_cnt=0 and v_cnt=0.
REQ-023 RUN SHALL be held until reset.
REQ-024 Counters SHALL run in every state; only fifo_read and vga_rgb depend on state.
REQ-025 fifo_read SHALL be combinational, high iff state=RUN, both counters are in the active area, and fifo_rempty=0.
REQ-026 vga_hs, vga_vs and vga_blank SHALL be registered, one cycle of latency from the counters.
REQ-027 vga_rgb SHALL equal the registered fifo_rdata in the same cycle, so that it aligns with vga_blank.
REQ-028 In the active area with state!=RUN, vga_rgb SHALL be 24'h000000.
REQ-029 When a read is required but fifo_rempty=1 (underflow), vga_rgb SHALL be 24'hFF00FF and underflow SHALL set on the next cycle.
REQ-030 underflow SHALL clear only on reset.
REQ-031 vga_rgb SHALL be 24'h000000 whenever vga_blank=0.
REQ-032 At h and v wrap occurring together, the next frame SHALL begin with no extra cycle.

Reset
REQ-033 On pixel_rst_n=0, counters SHALL be 0, state SHALL be IDLE, and outputs SHALL be: vga_hs=1, vga_vs=1, vga_blank=0, vga_rgb=0, underflow=0, fifo_read=0.
REQ-034 Reset asserted mid-frame SHALL abort immediately; after release, a full WAIT_FILL sequence SHALL be repeated.

Configuration
REQ-035 With macro VGA_TEST_PATTERN_EN defined, the FIFO SHALL be ignored and fifo_read held 0.
REQ-036 With VGA_TEST_PATTERN_EN defined, the FSM SHALL enter RUN at the first frame start and never report underflow.
REQ-037 With VGA_TEST_PATTERN_EN defined, vga_rgb SHALL be 8 vertical colour bars, bar = active x*8/HDISP, colour {R,G,B}={bar[2],bar[1],bar[0]} with each bit replicated x8.
REQ-038 Without VGA_TEST_PATTERN_EN, behaviour SHALL be as in Function, and no pattern logic SHALL be synthesised.

Structure
REQ-039 Package vga_pkg SHALL hold the FSM state typedef, the default timing constants and the underflow colour constant.
REQ-040 A single sub-module vga_counter SHALL be used twice, for horizontal and vertical counting: parameterised modulus, enable input, wrap output.

Verification
REQ-041 Timing check: HDISP=160, VDISP=90, FIFO always full -> HTOT=288, VTOT=135; vga_hs low for 48 cycles starting at h_cnt=40; vga_vs low for 3 lines; 38880 cycles per frame.
REQ-042 Start check: fifo_wfull raised at mid-frame -> RUN at the next (0,0), no fifo_read before it, black active pixels in the first partial frame.
REQ-043 Data alignment check: FIFO supplies incrementing words -> first visible pixel of a line equals the first word popped, one cycle after fifo_read; 160 reads per line.
REQ-044 Underflow check: force fifo_rempty=1 for 5 active cycles in RUN -> 5 pixels of FF00FF, underflow=1 until reset, no fifo_read during those cycles.
REQ-045 Reset check: assert pixel_rst_n=0 at v_cnt=60 -> all outputs at reset values within the same cycle; after release, frame restarts through WAIT_FILL.
REQ-046 Test-pattern check: with VGA_TEST_PATTERN_EN defined -> line pixels 0-19 = 000000, 20-39 = 0000FF, ..., 140-159 = FFFFFF; fifo_read never high.
